multi_tick_gen: RTL and testbench

- Parametrised, multi-channel successor to the single slow-clock divider.
- Each of NUM_CH channels has its own runtime-programmable divisor, periodic or one-shot mode, and start/stop control.
- Each channel produces a one-cycle tick and a 50%-duty toggle output.
- Feeds game timers, animation rates and countdowns from the single system clock.

---
 rtl/multi_tick_gen.sv | 119 +++++++++++
 tb/tb_multi_tick_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_tick_gen.sv
// Multi-channel programmable tick generator: per-channel divisor, periodic/one-shot
// mode, start/stop control, one-cycle tick and 50%-duty toggle outputs.
`timescale 1ns/1ps
module multi_tick_gen #(
   parameter  int NUM_CH      = 4,
   parameter  int CNT_W       = 26,
   parameter  int DEFAULT_DIV = 50000000,
   parameter  int AUTO_START  = 1,
   localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              freeze,
   input  logic [NUM_CH-1:0] start,
   input  logic [NUM_CH-1:0] stop,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              cfg_oneshot,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] duty50,
   output logic [NUM_CH-1:0] running
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

   state_e            state_q [NUM_CH];
   state_e            state_d [NUM_CH];
   logic [CNT_W-1:0]  cnt_q   [NUM_CH];
   logic [CNT_W-1:0]  cnt_d   [NUM_CH];
   logic [CNT_W-1:0]  div_q   [NUM_CH];
   logic [CNT_W-1:0]  div_d   [NUM_CH];
   logic [NUM_CH-1:0] os_q, os_d;
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic [NUM_CH-1:0] duty_q, duty_d;
   logic [NUM_CH-1:0] cfg_hit;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_q[i] <= (AUTO_START != 0) ? RUN : IDLE;
            cnt_q[i]   <= '0;
            div_q[i]   <= DIV_RST;
         end
         os_q   <= '0;
         tick_q <= '0;
         duty_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            div_q[i]   <= div_d[i];
         end
         os_q   <= os_d;
         tick_q <= tick_d;
         duty_q <= duty_d;
      end
   end

   // Priority per channel: stop > cfg > start > count; freeze only blocks counting.
   always_comb begin
      os_d    = os_q;
      tick_d  = '0;
      duty_d  = duty_q;
      cfg_hit = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         div_d[i]   = div_q[i];
         cfg_hit[i] = cfg_we && (cfg_ch == i[CH_W-1:0]);
         if (cfg_hit[i]) begin
            div_d[i] = cfg_div;
            os_d[i]  = cfg_oneshot;
         end
         if (stop[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            duty_d[i]  = 1'b0;
         end else if (cfg_hit[i] || start[i]) begin
            // A zero divisor parks the channel; otherwise restart on the divisor now in force.
            if (div_d[i] == '0) begin
               state_d[i] = IDLE;
               cnt_d[i]   = '0;
            end else if (start[i] || (state_q[i] == RUN)) begin
               state_d[i] = RUN;
               cnt_d[i]   = '0;
            end
         end else if ((state_q[i] == RUN) && !freeze) begin
            if (div_q[i] == '0) begin
               state_d[i] = IDLE;
               cnt_d[i]   = '0;
            end else if (cnt_q[i] == (div_q[i] - CNT_ONE)) begin
               cnt_d[i]  = '0;
               tick_d[i] = 1'b1;
               duty_d[i] = ~duty_q[i];
               if (os_q[i]) begin
                  state_d[i] = IDLE;
               end
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end
   end

   always_comb begin
      running = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         running[i] = (state_q[i] == RUN);
      end
   end

   assign tick   = tick_q;
   assign duty50 = duty_q;

endmodule

// File: tb/tb_multi_tick_gen.sv
// Scoreboard bench for multi_tick_gen: per-channel queues of expected {tick,duty50,running}
// snapshots at given cycles; any tick not announced in a queue is an error.
`timescale 1ns/1ps
module tb_multi_tick_gen;

   localparam int NCH = 3;   // three channels so that cfg_ch=3 is encodable yet out of range
   localparam int CW  = 8;

   typedef struct {
      int   cy;
      logic t;
      logic d;
      logic r;
   } exp_t;

   logic           clk = 1'b0;
   logic           resetN;
   logic           freeze;
   logic [NCH-1:0] start, stop;
   logic           cfg_we;
   logic [1:0]     cfg_ch;
   logic [CW-1:0]  cfg_div;
   logic           cfg_oneshot;
   logic [NCH-1:0] tick, duty50, running;

   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t expq [NCH][$];
   exp_t e;

   multi_tick_gen #(
      .NUM_CH      (NCH),
      .CNT_W       (CW),
      .DEFAULT_DIV (4),
      .AUTO_START  (1)
   ) dut (
      .clk         (clk),
      .resetN      (resetN),
      .freeze      (freeze),
      .start       (start),
      .stop        (stop),
      .cfg_we      (cfg_we),
      .cfg_ch      (cfg_ch),
      .cfg_div     (cfg_div),
      .cfg_oneshot (cfg_oneshot),
      .tick        (tick),
      .duty50      (duty50),
      .running     (running)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push_exp(input int c, input int cy, input logic t, input logic d, input logic r);
      exp_t x;
      x.cy = cy; x.t = t; x.d = d; x.r = r;
      expq[c].push_back(x);
   endtask

   task automatic go(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: consumes announced snapshots, flags stale ones and unannounced ticks.
   always @(negedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         while (expq[c].size() > 0 && expq[c][0].cy < cyc) begin
            e = expq[c].pop_front();
            checks++;
            errors++;
            $display("FAIL missed_ch%0d_cyc%0d: got no sample, required one at cycle %0d", c, e.cy, e.cy);
         end
         if (expq[c].size() > 0 && expq[c][0].cy == cyc) begin
            e = expq[c].pop_front();
            checks++;
            if ({tick[c], duty50[c], running[c]} !== {e.t, e.d, e.r}) begin
               errors++;
               $display("FAIL snap_ch%0d_cyc%0d: tick/duty50/running got %b%b%b required %b%b%b",
                        c, cyc, tick[c], duty50[c], running[c], e.t, e.d, e.r);
            end
         end else begin
            checks++;
            if (tick[c] !== 1'b0) begin
               errors++;
               $display("FAIL stray_tick_ch%0d_cyc%0d: tick got %b required 0", c, cyc, tick[c]);
            end
         end
      end
   end

   initial begin
      #3000;
      $display("FAIL timeout: simulation did not reach its end at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      resetN = 1'b0; freeze = 1'b0; start = '0; stop = '0;
      cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_oneshot = 1'b0;

      // Reset defaults: div 4, periodic, running; ticks 4/8/12 cycles after release edge 2.
      for (int c = 0; c < NCH; c++) begin
         push_exp(c, 1, 1'b0, 1'b0, 1'b1);
         push_exp(c, 6, 1'b1, 1'b1, 1'b1);
         push_exp(c, 10, 1'b1, 1'b0, 1'b1);
         push_exp(c, 14, 1'b1, 1'b1, 1'b1);
      end
      go(2);
      resetN = 1'b1;

      // ch1 -> div 3 one-shot while running, then start: single tick 3 edges later.
      push_exp(2, 15, 1'b0, 1'b0, 1'b0);
      push_exp(1, 16, 1'b0, 1'b1, 1'b1);
      push_exp(1, 19, 1'b1, 1'b0, 1'b0);
      push_exp(0, 18, 1'b1, 1'b0, 1'b1);
      push_exp(0, 22, 1'b1, 1'b1, 1'b1);
      go(14);
      stop = 3'b100; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3; cfg_oneshot = 1'b1;
      go(15);
      stop = '0; cfg_we = 1'b0; start = 3'b010;
      go(16);
      start = '0;

      // ch0 restart at count 2, then start+stop together.
      push_exp(0, 25, 1'b0, 1'b1, 1'b1);
      push_exp(0, 29, 1'b1, 1'b0, 1'b1);
      push_exp(0, 33, 1'b1, 1'b1, 1'b1);
      push_exp(0, 37, 1'b1, 1'b0, 1'b1);
      push_exp(0, 39, 1'b0, 1'b0, 1'b0);
      go(24);
      start = 3'b001;
      go(25);
      start = '0;
      go(38);
      start = 3'b001; stop = 3'b001;
      go(39);
      start = '0; stop = '0;

      // ch1: div 1 with same-cycle start, then div 0, then a start that must be ignored.
      push_exp(1, 45, 1'b0, 1'b0, 1'b1);
      push_exp(1, 46, 1'b1, 1'b1, 1'b1);
      push_exp(1, 47, 1'b1, 1'b0, 1'b1);
      push_exp(1, 48, 1'b1, 1'b1, 1'b1);
      push_exp(1, 49, 1'b1, 1'b0, 1'b1);
      push_exp(1, 50, 1'b0, 1'b0, 1'b0);
      push_exp(1, 53, 1'b0, 1'b0, 1'b0);
      go(44);
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd1; cfg_oneshot = 1'b0; start = 3'b010;
      go(45);
      cfg_we = 1'b0; start = '0;
      go(49);
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd0;
      go(50);
      cfg_we = 1'b0;
      go(52);
      start = 3'b010;
      go(53);
      start = '0;

      // Out-of-range cfg_ch, then start all: ch0/ch2 still div 4, ch1 still div 0.
      // Freeze 5 cycles at count 1 pushes the tick from cycle 62 to 67.
      push_exp(2, 56, 1'b0, 1'b0, 1'b0);
      push_exp(1, 58, 1'b0, 1'b0, 1'b0);
      push_exp(0, 58, 1'b0, 1'b0, 1'b1);
      push_exp(2, 58, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < NCH; c = c + 2) begin
         push_exp(c, 62, 1'b0, 1'b0, 1'b1);
         push_exp(c, 67, 1'b1, 1'b1, 1'b1);
         push_exp(c, 71, 1'b1, 1'b0, 1'b1);
      end
      go(55);
      cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd2; cfg_oneshot = 1'b0;
      go(56);
      cfg_we = 1'b0;
      go(57);
      start = 3'b111;
      go(58);
      start = '0;
      go(59);
      freeze = 1'b1;
      go(64);
      freeze = 1'b0;

      // Reset at count 2 of a div-4 period: no tick at 75, schedule restarts from 0.
      for (int c = 0; c < NCH; c++) begin
         push_exp(c, 74, 1'b0, 1'b0, 1'b1);
         push_exp(c, 78, 1'b1, 1'b1, 1'b1);
         push_exp(c, 82, 1'b1, 1'b0, 1'b1);
      end
      go(73);
      resetN = 1'b0;
      go(74);
      resetN = 1'b1;
      go(84);
      @(negedge clk);
      #1;

      for (int c = 0; c < NCH; c++) begin
         checks++;
         if (expq[c].size() != 0) begin
            errors++;
            $display("FAIL leftover_ch%0d: got %0d pending samples, required 0", c, expq[c].size());
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
